// File: rtl/cpu_ctrl_pkg.sv
// Shared types, key indices and the free-run divisor helper for the CPU
// step/run clock-enable controller.
package cpu_ctrl_pkg;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  localparam int KEY_STEP  = 0;
  localparam int KEY_MODE  = 1;
  localparam int KEY_SPEED = 2;
  localparam int NUM_KEYS  = 3;

  // Each speed step divides the base period by four.
  function automatic int unsigned run_divisor(input int unsigned run_div,
                                              input logic [1:0]  spd);
    return run_div >> (2 * spd);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button path: 2-flop synchroniser, counting debouncer and a
// registered one-cycle pulse on each accepted press (stable 1 -> 0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic            r_stable_d;
  logic            r_press;
  logic [DB_W-1:0] r_cnt;

  logic w_mismatch;
  logic w_accept;

  assign w_mismatch = (r_sync2 != r_stable);
  assign w_accept   = w_mismatch && (r_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      // Any return to agreement restarts the count, so short glitches never land.
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for cpu_16bit: debounced board keys drive a
// STEP/RUN mode FSM and a speed-selectable free-run prescaler.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int RUN_DIV         = 25000000,
  parameter int DIV_W           = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_n,
  output logic       cpu_en,
  output logic       run_mode,
  output logic [1:0] speed,
  output logic [2:0] key_pulse
);

  logic [NUM_KEYS-1:0] w_key_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
      ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_key_n(key_n[gi]),
        .o_press(w_key_pulse[gi])
      );
    end
  endgenerate

  mode_e            r_state;
  mode_e            w_state_next;
  logic [1:0]       r_speed;
  logic [1:0]       w_speed_next;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_cnt_next;
  logic [DIV_W-1:0] w_div_last;
  logic             r_cpu_en;
  logic             w_cpu_en_next;

  logic w_step_p;
  logic w_mode_p;
  logic w_speed_p;

  assign w_step_p   = w_key_pulse[KEY_STEP];
  assign w_mode_p   = w_key_pulse[KEY_MODE];
  assign w_speed_p  = w_key_pulse[KEY_SPEED];
  assign w_div_last = DIV_W'(run_divisor(RUN_DIV, r_speed) - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MODE_STEP;
      r_speed   <= 2'd0;
      r_div_cnt <= '0;
      r_cpu_en  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_speed   <= w_speed_next;
      r_div_cnt <= w_div_cnt_next;
      r_cpu_en  <= w_cpu_en_next;
    end
  end

  // All pulses are judged against the current (pre-transition) state.
  always_comb begin
    w_state_next   = r_state;
    w_speed_next   = r_speed;
    w_div_cnt_next = r_div_cnt;
    w_cpu_en_next  = 1'b0;

    if (w_mode_p) begin
      w_state_next = (r_state == MODE_STEP) ? MODE_RUN : MODE_STEP;
    end
    if (w_speed_p) begin
      w_speed_next = r_speed + 2'd1;
    end

    case (r_state)
      MODE_STEP: begin
        w_div_cnt_next = '0;
        w_cpu_en_next  = w_step_p;
      end
      MODE_RUN: begin
        // Leaving RUN or changing speed restarts the period with no enable.
        if (w_mode_p || w_speed_p) begin
          w_div_cnt_next = '0;
        end else if (r_div_cnt == w_div_last) begin
          w_div_cnt_next = '0;
          w_cpu_en_next  = 1'b1;
        end else begin
          w_div_cnt_next = r_div_cnt + DIV_W'(1);
        end
      end
      default: begin
        w_state_next   = MODE_STEP;
        w_div_cnt_next = '0;
      end
    endcase
  end

  assign cpu_en    = r_cpu_en;
  assign run_mode  = (r_state == MODE_RUN);
  assign speed     = r_speed;
  assign key_pulse = w_key_pulse;

endmodule
